// File: rtl/mkr_pin_pkg.sv
// Shared constants for the MKR header pin multiplexer: pin modes, flat pin index bases
// and the configuration FSM state encoding.
package mkr_pin_pkg;

    // Per-pin run-time modes, as written on cfg_mode.
    localparam logic [1:0] MODE_HIZ    = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_SRC    = 2'd2;
    localparam logic [1:0] MODE_PULSE  = 2'd3;

    // Default header population: 7 analog pins alongside AREF and the digital pins.
    localparam int unsigned DEFAULT_A_WIDTH = 7;
    localparam int unsigned DEFAULT_D_WIDTH = 15;

    // Flat vector layout is {bMKR_D, bMKR_A, bMKR_AREF}.
    localparam int unsigned IDX_AREF = 0;
    localparam int unsigned IDX_A    = 1;

    // The digital base moves with the analog pin count, so it is derived per instance.
    function automatic int unsigned idx_d(input int unsigned a_width);
        return IDX_A + a_width;
    endfunction

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBreak = 2'd1,
        StApply = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/mkr_pin_cell.sv
// One pad's worth of state: mode/value registers, trigger edge detect, pulse counter and the
// registered oe/out pair that the top level turns into a tristate driver.
module mkr_pin_cell
    import mkr_pin_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       brk_i,
    input  logic       apply_i,
    input  logic       upd_i,
    input  logic [1:0] new_mode_i,
    input  logic       new_value_i,
    input  logic       src_i,
    input  logic       trig_i,
    output logic [1:0] mode_o,
    output logic       oe_o,
    output logic       out_o
);

    localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);

    logic [1:0]      mode_q, mode_d;
    logic            value_q, value_d;
    logic            oe_q, oe_d;
    logic            out_q, out_d;
    logic            trig_q, trig_qq;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise;

    // Next-state for mode/value, pulse counter and the registered pad driver.
    always_comb begin
        mode_d  = apply_i ? new_mode_i : mode_q;
        value_d = (apply_i || upd_i) ? new_value_i : value_q;
        rise    = trig_q && !trig_qq;

        cnt_d = cnt_q;
        if (!enable_i || apply_i || (mode_d != MODE_PULSE)) begin
            // A disabled header cancels any pulse outright; it does not resume later.
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (rise) begin
            cnt_d = CntW'(PULSE_CYCLES);
        end

        // brk_i keeps the pad floating for the whole turnaround, whatever the old mode was.
        oe_d = (mode_d != MODE_HIZ) && !brk_i;

        out_d = 1'b0;
        case (mode_d)
            MODE_HIZ:    out_d = 1'b0;
            MODE_STATIC: out_d = value_d;
            MODE_SRC:    out_d = src_i;
            MODE_PULSE:  out_d = (cnt_d != '0);
            default:     out_d = 1'b0;
        endcase
    end

    // Per-pin state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode_q  <= MODE_HIZ;
            value_q <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            trig_q  <= 1'b0;
            trig_qq <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            value_q <= value_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            trig_q  <= trig_i;
            trig_qq <= trig_q;
            cnt_q   <= cnt_d;
        end
    end

    assign mode_o = mode_q;
    assign oe_o   = oe_q;
    assign out_o  = out_q;

endmodule

// File: rtl/mkr_pin_mux.sv
// Registered pin multiplexer for the MKR header. Owns the break-before-make configuration
// FSM, the pad tristate drivers and the readback synchronisers; per-pin state lives in
// mkr_pin_cell.
module mkr_pin_mux
    import mkr_pin_pkg::*;
#(
    parameter int unsigned A_WIDTH      = DEFAULT_A_WIDTH,
    parameter int unsigned D_WIDTH      = DEFAULT_D_WIDTH,
    parameter int unsigned N_PINS       = 1 + A_WIDTH + D_WIDTH,
    parameter int unsigned TURNAROUND   = 2,
    parameter int unsigned PULSE_CYCLES = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(N_PINS)-1:0] cfg_pin,
    input  logic [1:0]                cfg_mode,
    input  logic                      cfg_value,
    input  logic [N_PINS-1:0]         src_out,
    input  logic [N_PINS-1:0]         pulse_trig,
    output logic [N_PINS-1:0]         pin_in,
    inout  wire                       bMKR_AREF,
    inout  wire  [A_WIDTH-1:0]        bMKR_A,
    inout  wire  [D_WIDTH-1:0]        bMKR_D
);

    localparam int unsigned PinW  = $clog2(N_PINS);
    localparam int unsigned CntW  = $clog2(TURNAROUND + 1);
    localparam int unsigned IdxD  = idx_d(A_WIDTH);

    cfg_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [PinW-1:0] pend_pin_q;
    logic [1:0]      pend_mode_q;
    logic            pend_value_q;
    logic            cfg_ready_q;

    logic            accept, pin_ok, start_brk, same_upd, apply_now;
    logic [1:0]      cur_mode, new_mode;
    logic            new_value;
    logic [1:0]      cell_mode [N_PINS];
    logic [N_PINS-1:0] pin_brk, pin_apply, pin_upd;
    logic [N_PINS-1:0] pad_oe, pad_out, pad_raw;
    logic [N_PINS-1:0] sync_q, pin_in_q;

    assign cfg_ready = cfg_ready_q;

    // Decode the current handshake against the addressed pin's live mode.
    always_comb begin
        accept    = cfg_valid && cfg_ready_q;
        pin_ok    = 32'(cfg_pin) < N_PINS;
        cur_mode  = pin_ok ? cell_mode[cfg_pin] : MODE_HIZ;
        start_brk = accept && pin_ok && (cfg_mode != cur_mode);
        same_upd  = accept && pin_ok && (cfg_mode == cur_mode);
        // The new driver is loaded on the last turnaround edge; StApply is the settle cycle.
        apply_now = (state_q == StBreak) && (cnt_q == CntW'(TURNAROUND - 1));
        new_mode  = apply_now ? pend_mode_q : cfg_mode;
        new_value = apply_now ? pend_value_q : cfg_value;
    end

    // Config FSM: IDLE accepts writes, BREAK floats the target pin, APPLY holds off one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_pin_q   <= '0;
            pend_mode_q  <= MODE_HIZ;
            pend_value_q <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_brk) begin
                        state_q      <= StBreak;
                        cnt_q        <= '0;
                        pend_pin_q   <= cfg_pin;
                        pend_mode_q  <= cfg_mode;
                        pend_value_q <= cfg_value;
                        cfg_ready_q  <= 1'b0;
                    end
                end
                StBreak: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (apply_now) begin
                        state_q <= StApply;
                    end
                end
                StApply: begin
                    state_q     <= StIdle;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_PINS; i++) begin : g_cell
        assign pin_brk[i]   = (start_brk && (cfg_pin == PinW'(i)))
                           || ((state_q == StBreak) && !apply_now && (pend_pin_q == PinW'(i)));
        assign pin_apply[i] = apply_now && (pend_pin_q == PinW'(i));
        assign pin_upd[i]   = same_upd && (cfg_pin == PinW'(i));

        mkr_pin_cell #(
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_cell (
            .clk_i       (clock),
            .rst_ni      (reset),
            .enable_i    (enable),
            .brk_i       (pin_brk[i]),
            .apply_i     (pin_apply[i]),
            .upd_i       (pin_upd[i]),
            .new_mode_i  (new_mode),
            .new_value_i (new_value),
            .src_i       (src_out[i]),
            .trig_i      (pulse_trig[i]),
            .mode_o      (cell_mode[i]),
            .oe_o        (pad_oe[i]),
            .out_o       (pad_out[i])
        );
    end

    // Pad drivers: the global enable gates every pad without touching the cell state.
    assign bMKR_AREF = (pad_oe[IDX_AREF] && enable) ? pad_out[IDX_AREF] : 1'bz;

    for (genvar k = 0; k < A_WIDTH; k++) begin : g_pad_a
        assign bMKR_A[k] = (pad_oe[IDX_A + k] && enable) ? pad_out[IDX_A + k] : 1'bz;
    end

    for (genvar k = 0; k < D_WIDTH; k++) begin : g_pad_d
        assign bMKR_D[k] = (pad_oe[IdxD + k] && enable) ? pad_out[IdxD + k] : 1'bz;
    end

    assign pad_raw = {bMKR_D, bMKR_A, bMKR_AREF};

    // Two-flop readback synchroniser on every pad, independent of mode.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= '0;
            pin_in_q <= '0;
        end else begin
            sync_q   <= pad_raw;
            pin_in_q <= sync_q;
        end
    end

    assign pin_in = pin_in_q;

endmodule

// File: tb/tb_mkr_pin_mux.sv
// Scoreboard bench for mkr_pin_mux: stimulus pushes timed expectations, a negedge monitor
// pops and compares them.
module tb_mkr_pin_mux;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 15;
    localparam int unsigned N  = 1 + AW + DW;
    localparam int Z = 2;              // pad code for hi-Z
    localparam int KPad = 0, KRdy = 1, KPin = 2;
    localparam logic [1:0] MHiz = 2'd0, MStatic = 2'd1, MSrc = 2'd2, MPulse = 2'd3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [4:0]   cfg_pin = '0;
    logic [1:0]   cfg_mode = '0;
    logic         cfg_value = 1'b0;
    logic [N-1:0] src_out = '0;
    logic [N-1:0] pulse_trig = '0;
    logic [N-1:0] pin_in;
    wire          aref;
    wire [AW-1:0] pa;
    wire [DW-1:0] pd;
    wire [N-1:0]  pz;
    wire [N-1:0]  pv;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int due;
        int kind;
        int idx;
        int exp;
    } sb_t;
    sb_t sb_q[$];

    mkr_pin_mux #(
        .A_WIDTH      (AW),
        .D_WIDTH      (DW),
        .TURNAROUND   (2),
        .PULSE_CYCLES (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pin    (cfg_pin),
        .cfg_mode   (cfg_mode),
        .cfg_value  (cfg_value),
        .src_out    (src_out),
        .pulse_trig (pulse_trig),
        .pin_in     (pin_in),
        .bMKR_AREF  (aref),
        .bMKR_A     (pa),
        .bMKR_D     (pd)
    );

    assign pz[0] = (aref === 1'bz);
    assign pv[0] = aref;
    for (genvar k = 0; k < AW; k++) begin : g_a
        assign pz[1 + k] = (pa[k] === 1'bz);
        assign pv[1 + k] = pa[k];
    end
    for (genvar k = 0; k < DW; k++) begin : g_d
        assign pz[1 + AW + k] = (pd[k] === 1'bz);
        assign pv[1 + AW + k] = pd[k];
    end

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int kind, input int idx);
        if (kind == KPad) return pz[idx] ? Z : int'(pv[idx]);
        if (kind == KRdy) return int'(cfg_ready);
        return int'(pin_in[idx]);
    endfunction

    task automatic expect_at(input int due, input int kind, input int idx, input int exp);
        sb_t e;
        e.due  = due;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = sb_q.size() - 1; k >= 0; k--) begin
                if (sb_q[k].due == cyc) begin
                    check($sformatf("k%0d_i%0d_c%0d", sb_q[k].kind, sb_q[k].idx, cyc),
                          observe(sb_q[k].kind, sb_q[k].idx), sb_q[k].exp);
                    sb_q.delete(k);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Issue one config write; t returns the cycle in which valid&&ready held.
    task automatic cfg_write(input int pin, input logic [1:0] mode, input logic val,
                             output int t);
        int guard;
        guard     = 0;
        t         = -1;
        cfg_pin   = 5'(pin);
        cfg_mode  = mode;
        cfg_value = val;
        cfg_valid = 1'b1;
        while (t < 0 && guard < 20) begin
            @(negedge clock);
            if (cfg_ready) t = cyc;
            @(posedge clock);
            #1;
            guard++;
        end
        cfg_valid = 1'b0;
        if (t < 0) check("cfg_accept_timeout", 0, 1);
    endtask

    initial begin
        int t, t2, u, p, e, guard;
        logic last_s;
        last_s = 1'b0;

        // Reset held for two edges with enable high.
        tick(2);
        @(negedge clock);
        for (int i = 0; i < int'(N); i++) check($sformatf("rst_pad%0d", i), observe(KPad, i), Z);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_pin_in", int'(pin_in), 0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Mode change HIZ -> STATIC 1 on pin 15.
        cfg_write(15, MStatic, 1'b1, t);
        expect_at(t + 1, KPad, 15, Z);
        expect_at(t + 2, KPad, 15, Z);
        expect_at(t + 3, KPad, 15, 1);
        expect_at(t + 3, KPad, 14, Z);
        expect_at(t + 3, KPad, 16, Z);
        for (int c = 1; c <= 3; c++) expect_at(t + c, KRdy, 0, 0);
        expect_at(t + 4, KRdy, 0, 1);
        expect_at(t + 5, KPin, 15, 1);
        tick(6);

        // Same-mode rewrite: new level next cycle, no handshake stall.
        cfg_write(15, MStatic, 1'b0, t);
        expect_at(t + 1, KPad, 15, 0);
        expect_at(t + 1, KRdy, 0, 1);
        expect_at(t + 2, KRdy, 0, 1);
        expect_at(t + 3, KPin, 15, 0);
        tick(4);

        // Pulse mode on pin 3 with a second edge during the active pulse.
        cfg_write(3, MPulse, 1'b0, t);
        expect_at(t + 1, KPad, 3, Z);
        expect_at(t + 2, KPad, 3, Z);
        expect_at(t + 3, KPad, 3, 0);
        expect_at(t + 4, KRdy, 0, 1);
        tick(4);
        u = cyc;
        pulse_trig[3] = 1'b1;
        expect_at(u + 1, KPad, 3, 0);
        for (int c = 2; c <= 6; c++) expect_at(u + c, KPad, 3, 1);
        expect_at(u + 7, KPad, 3, 0);
        expect_at(u + 8, KPad, 3, 0);
        tick(1);
        pulse_trig[3] = 1'b0;
        tick(2);
        pulse_trig[3] = 1'b1;
        tick(1);
        pulse_trig[3] = 1'b0;
        tick(6);

        // SRC mode on pin 20 following a random pattern with one cycle of lag.
        src_out = '0;
        cfg_write(20, MSrc, 1'b0, t);
        expect_at(t + 1, KPad, 20, Z);
        expect_at(t + 2, KPad, 20, Z);
        expect_at(t + 3, KPad, 20, 0);
        tick(3);
        for (int j = 0; j < 8; j++) begin
            u = cyc;
            last_s = (j % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            src_out = N'($urandom);
            src_out[20] = last_s;
            expect_at(u + 1, KPad, 20, int'(last_s));
            expect_at(u + 1, KPad, 15, 0);
            expect_at(u + 3, KPin, 20, int'(last_s));
            tick(1);
        end
        tick(4);

        // Dropping enable mid-pulse cancels the pulse for good.
        p = cyc;
        pulse_trig[3] = 1'b1;
        tick(1);
        pulse_trig[3] = 1'b0;
        tick(2);
        enable = 1'b0;
        for (int i = 0; i < int'(N); i++) expect_at(p + 4, KPad, i, Z);
        tick(2);
        enable = 1'b1;
        expect_at(p + 5, KPad, 3, 0);
        expect_at(p + 6, KPad, 3, 0);
        expect_at(p + 6, KPad, 15, 0);
        tick(3);

        // Config keeps working with enable low; out-of-range pin is accepted and ignored.
        enable = 1'b0;
        cfg_write(31, MStatic, 1'b1, t);
        expect_at(t + 1, KRdy, 0, 1);
        expect_at(t + 1, KPad, 15, Z);
        cfg_write(5, MStatic, 1'b1, t2);
        for (int c = 1; c <= 3; c++) expect_at(t2 + c, KRdy, 0, 0);
        expect_at(t2 + 3, KPad, 5, Z);
        expect_at(t2 + 4, KRdy, 0, 1);
        tick(3);
        enable = 1'b1;
        e = cyc;
        expect_at(e, KPad, 5, 1);
        expect_at(e, KPad, 15, 0);
        expect_at(e, KPad, 3, 0);
        expect_at(e, KPad, 20, int'(last_s));
        expect_at(e, KPad, 8, Z);
        expect_at(e, KPad, 0, Z);
        expect_at(e, KPad, 22, Z);
        tick(3);

        // Reset during BREAK discards the pending change.
        cfg_write(7, MStatic, 1'b1, t);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        expect_at(t + 2, KRdy, 0, 1);
        expect_at(t + 3, KRdy, 0, 1);
        for (int c = 2; c <= 5; c++) expect_at(t + c, KPad, 7, Z);
        expect_at(t + 2, KPad, 15, Z);
        expect_at(t + 2, KPad, 5, Z);
        expect_at(t + 2, KPin, 5, 0);
        tick(6);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            tick(1);
            guard++;
        end
        check("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mkr_pin_mux.md
# mkr_pin_mux

Parametrised, registered pin multiplexer for the MKR header: AREF, A and D pads as one flat pin vector.
- Each pin has a run-time mode: hi-Z input, static level, peripheral passthrough or timed pulse.
- Mode changes are break-before-make: the pin floats for a fixed turnaround before the new driver turns on.
- Sits between the SAM-side pin bus and the top-level inouts; replaces the fixed single-pin enable assignment.

## Interface
Parameters:
- A_WIDTH, 7, number of bMKR_A pins
- D_WIDTH, 15, number of bMKR_D pins
- N_PINS, 1+A_WIDTH+D_WIDTH, flat pin count (derived, do not override)
- TURNAROUND, 2, hi-Z cycles inserted on any mode change (≥1)
- PULSE_CYCLES, 5, high time of a pulse-mode output (≥1)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  global output enable; low forces every pad hi-Z
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&&ready
- cfg_pin  in  $clog2(N_PINS)  target pin index
- cfg_mode  in  2  0=HIZ, 1=STATIC, 2=SRC, 3=PULSE
- cfg_value  in  1  level for STATIC mode
- src_out  in  N_PINS  peripheral drive values, used in SRC mode
- pulse_trig  in  N_PINS  pulse triggers, used in PULSE mode
- pin_in  out  N_PINS  synchronised pad readback
- bMKR_AREF  inout  1  flat index 0
- bMKR_A  inout  A_WIDTH  flat indices 1..A_WIDTH
- bMKR_D  inout  D_WIDTH  flat indices A_WIDTH+1..N_PINS-1

## Operation
- Flat vector is {bMKR_D, bMKR_A, bMKR_AREF}; index 0 = AREF.
- Per pin: registered mode[1:0], value, oe, out.
- Pad drives out when oe=1 and enable=1; otherwise it is 1'bz.
- Mode behaviour:
  - HIZ: oe=0.
  - STATIC: out=value.
  - SRC: out=src_out[i], registered.
  - PULSE: a rising edge on pulse_trig[i] (registered edge detect) drives out=1 for exactly PULSE_CYCLES cycles, then 0. Edges during an active pulse are ignored.
- Config FSM states:
  - IDLE: cfg_ready=1.
  - On an accepted write with cfg_mode ≠ current mode of cfg_pin → BREAK.
  - On an accepted write with the same mode: value is updated, FSM stays in IDLE.
  - BREAK: cfg_ready=0; target pin oe=0; counts TURNAROUND cycles → APPLY.
  - APPLY: writes new mode/value; pulse counter cleared; → IDLE.
- cfg_pin ≥ N_PINS: the write is accepted (handshake completes) and ignored; no state change.
- enable low:
  - all pads hi-Z and all pulse counters held at 0.
  - config writes and the FSM continue normally.
  - in-flight pulses are cancelled, not resumed.
- pin_in: 2-flop synchroniser on every pad, independent of mode.

## Timing
- Reset values: cfg_ready=1, all modes HIZ, value=0, oe=0, out=0, pin_in=0, pulse counters 0, FSM=IDLE, all pads hi-Z.
- Same-mode write accepted at cycle t: new level on the pad at t+1.
- Mode-change write accepted at t:
  - pin hi-Z during t+1..t+TURNAROUND.
  - new driver active at t+TURNAROUND+1.
  - cfg_ready low during t+1..t+TURNAROUND+1, high again at t+TURNAROUND+2.
- SRC mode: pad = src_out delayed 1 cycle.
- PULSE mode: trig rises at t → pad high during t+2..t+PULSE_CYCLES+1.
- pin_in latency: 2 cycles from the pad.
- Reset mid-BREAK: returns to the reset state next edge; the pending change is discarded.

## Structure
- Package mkr_pin_pkg:
  - mode constants MODE_HIZ/STATIC/SRC/PULSE
  - pin index bases IDX_AREF=0, IDX_A=1, IDX_D=1+A_WIDTH
  - cfg FSM state encoding
- Sub-module mkr_pin_cell, instantiated N_PINS times by generate. It holds the mode/value regs, edge detect, pulse counter and oe/out.
- Top level holds the config FSM, turnaround counter and pad tristate assigns.

## Test plan
- Reset low 2 cycles → all 23 pads z, pin_in=0, cfg_ready=1.
- Write pin 15 STATIC value=1, enable=1 → pad 15 z for 2 cycles, then 1; cfg_ready low 3 cycles.
- Rewrite pin 15 STATIC value=0 → pad 0 next cycle, cfg_ready stays high.
- Pin 3 PULSE, trig edge at t → pad 3 high t+2..t+6; second trig edge at t+3 is ignored.
- Pin 20 SRC, src_out[20] toggling → pad follows with 1-cycle lag.
- Drop enable → all pads z next cycle; cfg_pin=31 write → handshake completes, no pin changes.
